// File: rtl/imem_dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_arbiter_pkg
// Description : Shared FSM encoding and constants for the unified I/D memory
//               port arbiter (MA_MEM_TIMEOUT_EN enables the BUSY timeout).
// Revision    : 1.0 - initial release
// ============================================================================
package imem_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int unsigned C_WAIT_W        = 4;
    localparam int unsigned C_TIMEOUT_LIMIT = 16;
    localparam int unsigned C_TIMEOUT_W     = 4;

endpackage
`default_nettype wire

// File: rtl/imem_dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_arbiter_if
// Description : Fetch, load/store and memory handshake bundle of the arbiter.
//               ma_o_err exists only when MA_MEM_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_dmem_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              ma_i_flush;
    logic              ma_i_if_syn;
    logic [AWIDTH-1:0] ma_i_if_addr;
    logic              ma_o_if_ack;
    logic              ma_o_if_stall;
    logic              ma_i_ds_syn;
    logic [AWIDTH-1:0] ma_i_ds_addr;
    logic              ma_i_ds_we;
    logic [DWIDTH-1:0] ma_i_ds_wdata;
    logic              ma_o_ds_ack;
    logic [DWIDTH-1:0] ma_o_rdata;
    logic              ma_o_mem_syn;
    logic [AWIDTH-1:0] ma_o_mem_addr;
    logic              ma_o_mem_we;
    logic [DWIDTH-1:0] ma_o_mem_wdata;
    logic              ma_i_mem_ack;
    logic [DWIDTH-1:0] ma_i_mem_rdata;
`ifdef MA_MEM_TIMEOUT_EN
    logic              ma_o_err;
`endif

    // Arbiter side: masters the shared memory port
    modport master (
`ifdef MA_MEM_TIMEOUT_EN
        output ma_o_err,
`endif
        input  ma_i_flush, ma_i_if_syn, ma_i_if_addr,
        input  ma_i_ds_syn, ma_i_ds_addr, ma_i_ds_we, ma_i_ds_wdata,
        input  ma_i_mem_ack, ma_i_mem_rdata,
        output ma_o_if_ack, ma_o_if_stall, ma_o_ds_ack, ma_o_rdata,
        output ma_o_mem_syn, ma_o_mem_addr, ma_o_mem_we, ma_o_mem_wdata
    );

    modport slave (
`ifdef MA_MEM_TIMEOUT_EN
        input  ma_o_err,
`endif
        output ma_i_flush, ma_i_if_syn, ma_i_if_addr,
        output ma_i_ds_syn, ma_i_ds_addr, ma_i_ds_we, ma_i_ds_wdata,
        output ma_i_mem_ack, ma_i_mem_rdata,
        input  ma_o_if_ack, ma_o_if_stall, ma_o_ds_ack, ma_o_rdata,
        input  ma_o_mem_syn, ma_o_mem_addr, ma_o_mem_we, ma_o_mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_dmem_prio.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_prio
// Description : IDLE-state grant logic (data first, fetch on starvation) and
//               the saturating count of fetch-lost arbitrations.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_prio
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  wire  ma_clk,
    input  wire  ma_rst,
    input  wire  i_idle,
    input  wire  i_flush,
    input  wire  i_if_syn,
    input  wire  i_ds_syn,
    output logic o_grant_if,
    output logic o_grant_ds
);

    logic [C_WAIT_W-1:0] r_wait;
    logic                w_starved;
    logic                w_if_req;

    // A flush in IDLE blocks fetch for that cycle only; data may still win
    assign w_if_req  = i_if_syn & ~i_flush;
    assign w_starved = (r_wait == C_WAIT_W'(MAX_WAIT));

    always_comb begin
        o_grant_if = 1'b0;
        o_grant_ds = 1'b0;
        if (i_idle) begin
            if (w_starved && w_if_req) begin
                o_grant_if = 1'b1;
            end else if (i_ds_syn) begin
                o_grant_ds = 1'b1;
            end else if (w_if_req) begin
                o_grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge ma_clk) begin
        if (!ma_rst) begin
            r_wait <= '0;
        end else if (o_grant_if) begin
            r_wait <= '0;
        end else if (o_grant_ds && i_if_syn && !w_starved) begin
            r_wait <= r_wait + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_arbiter
// Description : Shares one memory port between fetch and load/store, with
//               fetch stall, flush cancel and anti-starvation.
//               MA_MEM_TIMEOUT_EN adds a 16-cycle BUSY abort and ma_o_err.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int          AWIDTH   = 32,
    parameter int          DWIDTH   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  wire                  ma_clk,
    input  wire                  ma_rst,
    imem_dmem_arbiter_if.master  bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_idle;
    logic              w_grant_if;
    logic              w_grant_ds;
    logic              w_mem_done;
    logic              w_abort;
    logic              w_if_ack;

    logic              r_mem_syn;
    logic [AWIDTH-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DWIDTH-1:0] r_mem_wdata;
    logic [DWIDTH-1:0] r_rdata;
    logic              r_if_ack;
    logic              r_ds_ack;
    logic              r_cancel;

    assign w_idle = (r_state == ST_IDLE);

    imem_dmem_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .ma_clk     (ma_clk),
        .ma_rst     (ma_rst),
        .i_idle     (w_idle),
        .i_flush    (bus.ma_i_flush),
        .i_if_syn   (bus.ma_i_if_syn),
        .i_ds_syn   (bus.ma_i_ds_syn),
        .o_grant_if (w_grant_if),
        .o_grant_ds (w_grant_ds)
    );

`ifdef MA_MEM_TIMEOUT_EN
    logic                   w_busy;
    logic [C_TIMEOUT_W-1:0] r_tmo_cnt;
    logic                   r_err;

    assign w_busy  = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
    assign w_abort = w_busy && !bus.ma_i_mem_ack &&
                     (r_tmo_cnt == C_TIMEOUT_W'(C_TIMEOUT_LIMIT - 1));

    always_ff @(posedge ma_clk) begin
        if (!ma_rst || !w_busy) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge ma_clk) begin
        if (!ma_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
        end
    end

    assign bus.ma_o_err = r_err;
`else
    assign w_abort = 1'b0;
`endif

    assign w_mem_done = bus.ma_i_mem_ack | w_abort;

    always_ff @(posedge ma_clk) begin
        if (!ma_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_ds) begin
                    w_state_nxt = ST_BUSY_D;
                end else if (w_grant_if) begin
                    w_state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (w_mem_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ma_clk) begin
        if (!ma_rst) begin
            r_mem_syn   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_if_ack    <= 1'b0;
            r_ds_ack    <= 1'b0;
            r_cancel    <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_ds_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_ds) begin
                        r_mem_syn   <= 1'b1;
                        r_mem_addr  <= bus.ma_i_ds_addr;
                        r_mem_we    <= bus.ma_i_ds_we;
                        r_mem_wdata <= bus.ma_i_ds_wdata;
                    end else if (w_grant_if) begin
                        r_mem_syn   <= 1'b1;
                        r_mem_addr  <= bus.ma_i_if_addr;
                        r_mem_we    <= 1'b0;
                        r_mem_wdata <= '0;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (w_mem_done) begin
                        r_mem_syn <= 1'b0;
                        r_rdata   <= w_abort ? '0 : bus.ma_i_mem_rdata;
                        if (r_state == ST_BUSY_I) begin
                            r_if_ack <= ~(r_cancel | bus.ma_i_flush);
                        end else begin
                            r_ds_ack <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // RESP always exits to IDLE, so the cancel flag clears there
            if (r_state == ST_RESP) begin
                r_cancel <= 1'b0;
            end else if (r_state == ST_BUSY_I && bus.ma_i_flush) begin
                r_cancel <= 1'b1;
            end
        end
    end

    // A flush landing in the fetch RESP cycle still has to kill the ack
    assign w_if_ack = r_if_ack & ~bus.ma_i_flush;

    assign bus.ma_o_if_ack    = w_if_ack;
    assign bus.ma_o_if_stall  = bus.ma_i_if_syn & ~w_if_ack;
    assign bus.ma_o_ds_ack    = r_ds_ack;
    assign bus.ma_o_rdata     = r_rdata;
    assign bus.ma_o_mem_syn   = r_mem_syn;
    assign bus.ma_o_mem_addr  = r_mem_addr;
    assign bus.ma_o_mem_we    = r_mem_we;
    assign bus.ma_o_mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_dmem_arbiter
// Description : Random fetch/load/store traffic against a memory model with a
//               queue scoreboard; MA_MEM_TIMEOUT_EN adds the timeout scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 2;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } exp_t;

    logic ma_clk = 1'b0;
    logic ma_rst = 1'b0;
    always #5 ma_clk = ~ma_clk;

    imem_dmem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    imem_dmem_arbiter #(
        .AWIDTH   (AW),
        .DWIDTH   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .ma_clk (ma_clk),
        .ma_rst (ma_rst),
        .bus    (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_if[$];
    exp_t        exp_ds[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] mem_arr[logic [31:0]];
    bit          mem_hold = 1'b0;
    int          lat      = 0;
    logic [31:0] m_addr;
    bit          e_if, e_ds, e_fl;
    int          losses   = 0;
    bit          prev_syn = 1'b0;
    int          n_ds_ack = 0;

    // Unwritten memory contents: odd multiplier keeps distinct addresses distinct
    function automatic logic [31:0] mval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_1F0D;
    endfunction

    function automatic logic [31:0] ref_val(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mval(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Request inputs as seen by the arbitration edge
    always @(posedge ma_clk) begin
        e_if = bus.ma_i_if_syn;
        e_ds = bus.ma_i_ds_syn;
        e_fl = bus.ma_i_flush;
    end

    // Monitor: pops expected responses and checks grant ordering rules
    always @(negedge ma_clk) begin
        exp_t e;
        if (!ma_rst) begin
            prev_syn = 1'b0;
            losses   = 0;
        end else begin
            check("if_stall", bus.ma_o_if_stall, bus.ma_i_if_syn & ~bus.ma_o_if_ack);
            if (bus.ma_o_if_ack) begin
                if (exp_if.size() == 0) check("if_ack_unexpected", exp_if.size(), 1);
                else check("if_rdata", bus.ma_o_rdata, exp_if.pop_front());
            end
            if (bus.ma_o_ds_ack) begin
                n_ds_ack++;
                if (exp_ds.size() == 0) check("ds_ack_unexpected", exp_ds.size(), 1);
                else begin
                    e = exp_ds.pop_front();
                    if (e.chk) check("ds_rdata", bus.ma_o_rdata, e.data);
                end
            end
            if (bus.ma_o_mem_syn && !prev_syn) begin
                if (bus.ma_o_mem_addr[31]) begin
                    check("grant_data_rule", 32'(e_ds && !(e_if && !e_fl && losses == MW)), 1);
                    if (e_if && losses < MW) losses++;
                end else begin
                    check("grant_fetch_rule", 32'(e_if && !e_fl && (!e_ds || losses == MW)), 1);
                    check("fetch_we", bus.ma_o_mem_we, 0);
                    losses = 0;
                end
            end
            prev_syn = bus.ma_o_mem_syn;
        end
    end

    // Memory: acks 1..3 cycles after mem_syn, holds a sparse word array
    initial begin
        bus.ma_i_mem_ack   = 1'b0;
        bus.ma_i_mem_rdata = '0;
        forever begin
            @(negedge ma_clk);
            #1;
            if (bus.ma_i_mem_ack) begin
                bus.ma_i_mem_ack   = 1'b0;
                bus.ma_i_mem_rdata = '0;
            end else if (ma_rst && bus.ma_o_mem_syn && !mem_hold) begin
                if (lat == 0) begin
                    m_addr = bus.ma_o_mem_addr;
                    if (bus.ma_o_mem_we) begin
                        mem_arr[m_addr]    = bus.ma_o_mem_wdata;
                        bus.ma_i_mem_rdata = $urandom;
                    end else begin
                        bus.ma_i_mem_rdata = mem_arr.exists(m_addr) ? mem_arr[m_addr] : mval(m_addr);
                    end
                    bus.ma_i_mem_ack = 1'b1;
                    lat = $urandom_range(0, 2);
                end else begin
                    lat--;
                end
            end
        end
    end

    task automatic drive_cycle(input bit allow_new);
        logic [31:0] a;
        @(posedge ma_clk);
        #1;
        bus.ma_i_flush = allow_new && ($urandom_range(0, 11) == 0);
        @(negedge ma_clk);
        #1;
        if (bus.ma_i_if_syn) begin
            if (bus.ma_o_if_ack) begin
                bus.ma_i_if_syn = 1'b0;
            end else if (bus.ma_i_flush) begin
                a = {16'h0, bus.ma_i_if_addr[15:0] + 16'(4 * (1 + $urandom_range(0, 63)))};
                bus.ma_i_if_addr = a;
                void'(exp_if.pop_back());
                exp_if.push_back(mval(a));
            end
        end
        if (!bus.ma_i_if_syn && allow_new && $urandom_range(0, 3) != 0) begin
            a = {16'h0, 16'($urandom_range(0, 16383) * 4)};
            bus.ma_i_if_addr = a;
            bus.ma_i_if_syn  = 1'b1;
            exp_if.push_back(mval(a));
        end
        if (bus.ma_i_ds_syn && bus.ma_o_ds_ack) bus.ma_i_ds_syn = 1'b0;
        if (!bus.ma_i_ds_syn && allow_new && $urandom_range(0, 9) < 8) begin
            a = 32'h8000_0000 | 32'($urandom_range(0, 7) * 4);
            bus.ma_i_ds_addr  = a;
            bus.ma_i_ds_we    = 1'($urandom_range(0, 1));
            bus.ma_i_ds_wdata = $urandom;
            if (bus.ma_i_ds_we) begin
                ref_mem[a] = bus.ma_i_ds_wdata;
                exp_ds.push_back('{1'b0, 32'h0});
            end else begin
                exp_ds.push_back('{1'b1, ref_val(a)});
            end
            bus.ma_i_ds_syn = 1'b1;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_syn"},   bus.ma_o_mem_syn,   0);
        check({tag, "_mem_addr"},  bus.ma_o_mem_addr,  0);
        check({tag, "_mem_we"},    bus.ma_o_mem_we,    0);
        check({tag, "_mem_wdata"}, bus.ma_o_mem_wdata, 0);
        check({tag, "_if_ack"},    bus.ma_o_if_ack,    0);
        check({tag, "_ds_ack"},    bus.ma_o_ds_ack,    0);
        check({tag, "_rdata"},     bus.ma_o_rdata,     0);
    endtask

    initial begin
        int  n_before;
        bit  done;
        bit  seen;
        bus.ma_i_flush    = 1'b0;
        bus.ma_i_if_syn   = 1'b0;
        bus.ma_i_if_addr  = '0;
        bus.ma_i_ds_syn   = 1'b0;
        bus.ma_i_ds_addr  = '0;
        bus.ma_i_ds_we    = 1'b0;
        bus.ma_i_ds_wdata = '0;

        repeat (3) @(posedge ma_clk);
        @(negedge ma_clk);
        check_outputs_zero("reset");
        check("reset_stall", bus.ma_o_if_stall, 0);
        #1 ma_rst = 1'b1;

        for (int c = 0; c < 3000; c++) drive_cycle(1'b1);

        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            drive_cycle(1'b0);
            done = (exp_if.size() == 0) && (exp_ds.size() == 0) &&
                   !bus.ma_i_if_syn && !bus.ma_i_ds_syn;
        end
        check("drain_complete", 32'(done), 1);

`ifdef MA_MEM_TIMEOUT_EN
        begin
            int busy_cycles;
            bit got;
            busy_cycles = 0;
            got = 1'b0;
            mem_hold = 1'b1;
            @(negedge ma_clk);
            #1;
            bus.ma_i_ds_addr = 32'h8000_0004;
            bus.ma_i_ds_we   = 1'b0;
            exp_ds.push_back('{1'b1, 32'h0});
            bus.ma_i_ds_syn  = 1'b1;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge ma_clk);
                if (bus.ma_o_mem_syn) busy_cycles++;
                if (bus.ma_o_ds_ack) begin
                    got = 1'b1;
                    check("tmo_err", bus.ma_o_err, 1);
                end
            end
            check("tmo_ack_seen", 32'(got), 1);
            check("tmo_busy_cycles", busy_cycles, 16);
            #1;
            bus.ma_i_ds_syn = 1'b0;
            mem_hold = 1'b0;
            repeat (3) @(negedge ma_clk);
        end
`endif

        // Reset while a load is outstanding in BUSY_D
        mem_hold = 1'b1;
        @(negedge ma_clk);
        #1;
        bus.ma_i_ds_addr = 32'h8000_0010;
        bus.ma_i_ds_we   = 1'b0;
        bus.ma_i_ds_syn  = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge ma_clk);
            seen = bus.ma_o_mem_syn;
        end
        check("rst_busy_reached", 32'(seen), 1);
        #1;
        ma_rst = 1'b0;
        bus.ma_i_ds_syn = 1'b0;
        n_before = n_ds_ack;
        @(negedge ma_clk);
        check_outputs_zero("midrst");
        #1;
        ma_rst   = 1'b1;
        mem_hold = 1'b0;
        repeat (10) @(negedge ma_clk);
        check("midrst_no_ds_ack", n_ds_ack, n_before);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
